// File: rtl/rv32i_control_unit.sv
// RV32I decode-stage control: main decoder, ALU decoder and a sticky
// illegal-opcode flag for the 5-stage pipeline.
module rv32i_control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       ALUSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] ResultSrc,
    output logic [2:0] ALU_Ctrl,
    output logic       Branch,
    output logic       Jump,
    output logic       Illegal,
    output logic       IllegalSeen
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] AOP_ADD  = 2'b00;
    localparam logic [1:0] AOP_SUB  = 2'b01;
    localparam logic [1:0] AOP_FUNC = 2'b10;

    logic       is_r;
    logic       is_ialu;
    logic       is_lw;
    logic       is_sw;
    logic       is_br;
    logic       is_jal;

    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] imm_src;
    logic [1:0] result_src;
    logic       branch;
    logic       jump;
    logic       illegal;
    logic [1:0] alu_op;
    logic [2:0] alu_ctrl;
    logic       sub_sel;

    assign is_r    = (Op == OP_R);
    assign is_ialu = (Op == OP_IALU);
    assign is_lw   = (Op == OP_LW);
    assign is_sw   = (Op == OP_SW);
    assign is_br   = (Op == OP_BR);
    assign is_jal  = (Op == OP_JAL);

    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        imm_src    = 2'b00;
        result_src = 2'b00;
        branch     = 1'b0;
        jump       = 1'b0;
        illegal    = 1'b0;
        alu_op     = AOP_ADD;
        unique case (1'b1)
            is_r: begin
                reg_write = 1'b1;
                alu_op    = AOP_FUNC;
            end
            is_ialu: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = AOP_FUNC;
            end
            is_lw: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = 2'b01;
            end
            is_sw: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = 2'b01;
            end
            is_br: begin
                imm_src = 2'b10;
                branch  = 1'b1;
                alu_op  = AOP_SUB;
            end
            is_jal: begin
                reg_write  = 1'b1;
                imm_src    = 2'b11;
                result_src = 2'b10;
                jump       = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Immediate forms (Op[5]=0) never subtract: ADDI ignores funct7.
    assign sub_sel = Op[5] & funct7[5];

    always_comb begin
        alu_ctrl = ALU_ADD;
        unique case (alu_op)
            AOP_ADD: alu_ctrl = ALU_ADD;
            AOP_SUB: alu_ctrl = ALU_SUB;
            AOP_FUNC: begin
                unique case (funct3)
                    3'b000:  alu_ctrl = sub_sel ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLT;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    // Everything is held quiet while reset is asserted.
    assign RegWrite  = rst_n & reg_write;
    assign MemWrite  = rst_n & mem_write;
    assign ALUSrc    = rst_n & alu_src;
    assign ImmSrc    = rst_n ? imm_src : 2'b00;
    assign ResultSrc = rst_n ? result_src : 2'b00;
    assign ALU_Ctrl  = rst_n ? alu_ctrl : 3'b000;
    assign Branch    = rst_n & branch;
    assign Jump      = rst_n & jump;
    assign Illegal   = rst_n & illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IllegalSeen <= 1'b0;
        end else if (illegal) begin
            IllegalSeen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rv32i_control_unit.sv
// Scoreboard bench for rv32i_control_unit: directed plan items followed
// by random opcodes, checked against a table-driven reference model.
module tb_rv32i_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] Op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic [6:0] funct7 = 7'b0000000;
    logic       RegWrite, MemWrite, ALUSrc, Branch, Jump;
    logic       Illegal, IllegalSeen;
    logic [1:0] ImmSrc, ResultSrc;
    logic [2:0] ALU_Ctrl;

    always #5 clk = ~clk;

    rv32i_control_unit dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .funct3(funct3),
        .funct7(funct7), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .ALUSrc(ALUSrc), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc),
        .ALU_Ctrl(ALU_Ctrl), .Branch(Branch), .Jump(Jump),
        .Illegal(Illegal), .IllegalSeen(IllegalSeen)
    );

    typedef struct packed {
        logic       rw;
        logic       mw;
        logic       asrc;
        logic [1:0] imm;
        logic [1:0] res;
        logic [2:0] alu;
        logic       br;
        logic       jmp;
        logic       ill;
        logic       seen;
    } exp_t;

    typedef struct {
        exp_t  e;
        string name;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    passed = 0;
    logic  seen_m = 1'b0;
    logic  last_ill = 1'b0;

    // ALU results for funct3 = 0..7 when funct3 selects the operation.
    logic [2:0] f3_tab [8] = '{3'd0, 3'd6, 3'd5, 3'd5,
                               3'd4, 3'd7, 3'd3, 3'd2};

    function automatic exp_t model(input logic r, input logic [6:0] op,
                                   input logic [2:0] f3,
                                   input logic [6:0] f7);
        exp_t e;
        e = '0;
        if (!r) return e;
        case (op)
            7'b0110011: begin
                e.rw = 1;
                e.alu = (f3 == 0) ? (f7[5] ? 3'd1 : 3'd0) : f3_tab[f3];
            end
            7'b0010011: begin
                e.rw = 1; e.asrc = 1;
                e.alu = f3_tab[f3];
            end
            7'b0000011: begin
                e.rw = 1; e.asrc = 1; e.res = 2'b01;
            end
            7'b0100011: begin
                e.mw = 1; e.asrc = 1; e.imm = 2'b01;
            end
            7'b1100011: begin
                e.br = 1; e.imm = 2'b10; e.alu = 3'd1;
            end
            7'b1101111: begin
                e.rw = 1; e.jmp = 1; e.imm = 2'b11; e.res = 2'b10;
            end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    task automatic apply(input logic r, input logic [6:0] op,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input string name);
        item_t it;
        @(posedge clk);
        if (rst_n && last_ill) seen_m = 1'b1;
        #1;
        rst_n = r; Op = op; funct3 = f3; funct7 = f7;
        if (!r) seen_m = 1'b0;
        it.e = model(r, op, f3, f7);
        last_ill = it.e.ill;
        it.e.seen = seen_m;
        it.name = name;
        q.push_back(it);
    endtask

    // Monitor: outputs are settled mid-cycle, well after the input change.
    initial begin
        item_t it;
        exp_t  act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                it = q.pop_front();
                act = '{RegWrite, MemWrite, ALUSrc, ImmSrc, ResultSrc,
                        ALU_Ctrl, Branch, Jump, Illegal, IllegalSeen};
                checks++;
                if (act === it.e) passed++;
                else $display("FAIL %s: got %b want %b (op=%b f3=%b f7=%b)",
                              it.name, act, it.e, Op, funct3, funct7);
            end
        end
    end

    initial begin
        logic [6:0] ops [6] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                7'b0100011, 7'b1100011, 7'b1101111};
        logic [6:0] rop;
        int waited;
        apply(0, 7'b0110011, 3'b000, 7'h00, "reset_rtype");
        apply(1, 7'b0110011, 3'b000, 7'h00, "reset_release_add");
        apply(1, 7'b0110011, 3'b000, 7'h20, "r_sub");
        for (int i = 1; i < 8; i++)
            apply(1, 7'b0110011, 3'(i), 7'h00, "r_sweep");
        apply(1, 7'b0010011, 3'b000, 7'h20, "addi_no_sub");
        apply(1, 7'b0010011, 3'b101, 7'h20, "srai_as_srl");
        apply(1, 7'b0000011, 3'b010, 7'h00, "lw");
        apply(1, 7'b0100011, 3'b010, 7'h00, "sw");
        apply(1, 7'b1100011, 3'b000, 7'h00, "beq");
        apply(1, 7'b1100011, 3'b111, 7'h7f, "bgeu");
        apply(1, 7'b1101111, 3'b000, 7'h00, "jal");
        apply(1, 7'b0110011, 3'b000, 7'h5f, "f7_ignored_bits");
        apply(1, 7'b1100111, 3'b000, 7'h00, "jalr_illegal");
        apply(1, 7'b0110011, 3'b000, 7'h00, "seen_sticky");
        apply(1, 7'b0110011, 3'b100, 7'h00, "seen_sticky2");
        apply(0, 7'b0110011, 3'b000, 7'h00, "async_clear");
        apply(1, 7'b0110011, 3'b000, 7'h00, "after_clear");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) rop = 7'($urandom);
            else rop = ops[$urandom_range(0, 5)];
            apply($urandom_range(0, 39) != 0, rop, 3'($urandom),
                  7'($urandom), "random");
        end
        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d items left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
